regfile_dump_reader: RTL

- Sequential reader that walks registers R0..LAST_REG through one shared read port of the 16x16 register file.
- Streams each value out over a valid/ready interface to the debug/trace path.
- Accumulates a 16-bit checksum of the dumped words.
- Sits beside the decode stage and borrows a read port only when the pipeline arbiter grants it.

---
 rtl/regfile_dump_reader.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader
// Walks registers 0..LAST_REG through one borrowed read port of the register
// file. Each value is presented on a valid/ready stream to the debug/trace
// path, and a wrapping 16-bit checksum of every captured word is kept.
// The read port is requested only in REQ. A word is captured in the cycle the
// arbiter grants the port. The word is then held in HOLD until the consumer
// accepts it.

module regfile_dump_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int LAST_REG   = 15
) (
  input  logic                  clk,
  input  logic                  rst,        // asynchronous, active low
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_reg,
  input  logic                  rd_gnt,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_idx,
  output logic [DATA_WIDTH-1:0] checksum
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(LAST_REG);
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = ADDR_WIDTH'(1);

  state_t                  state_reg;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   idx_reg;
  logic [DATA_WIDTH-1:0]   out_data_reg;
  logic [ADDR_WIDTH-1:0]   out_idx_reg;
  logic [DATA_WIDTH-1:0]   checksum_reg;

  // Qualified events. abort outranks both grant and accept.
  logic start_take;
  logic grant_take;
  logic accept_take;
  logic last_word;

  assign start_take  = (state_reg == IDLE) && start;
  assign grant_take  = (state_reg == REQ)  && !abort && rd_gnt;
  assign accept_take = (state_reg == HOLD) && !abort && out_ready;
  assign last_word   = (idx_reg == LAST_IDX);

  // State register. Reset returns to IDLE immediately, with no done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. REQ waits for a grant with no timeout.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (abort) begin
          state_next = IDLE;
        end else if (rd_gnt) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (abort) begin
          state_next = IDLE;
        end else if (out_ready) begin
          state_next = last_word ? DONE : REQ;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    rd_en     = 1'b0;
    out_valid = 1'b0;
    unique case (state_reg)
      IDLE: begin
        busy = 1'b0;
      end
      REQ: begin
        busy  = 1'b1;
        rd_en = 1'b1;
      end
      HOLD: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Register index. It restarts at 0 on an accepted start and advances after each
  // accepted word except the last.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_reg <= '0;
    end else if (start_take) begin
      idx_reg <= '0;
    end else if (accept_take && !last_word) begin
      idx_reg <= idx_reg + IDX_ONE;
    end
  end

  // Capture the granted word and its index. Both stay stable through HOLD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data_reg <= '0;
      out_idx_reg  <= '0;
    end else if (grant_take) begin
      out_data_reg <= rd_data;
      out_idx_reg  <= idx_reg;
    end
  end

  // Running checksum. It is cleared only by an accepted start, so an aborted
  // dump keeps its partial sum and a finished dump keeps its final sum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      checksum_reg <= '0;
    end else if (start_take) begin
      checksum_reg <= '0;
    end else if (grant_take) begin
      checksum_reg <= checksum_reg + rd_data;
    end
  end

  assign rd_reg   = idx_reg;
  assign out_data = out_data_reg;
  assign out_idx  = out_idx_reg;
  assign checksum = checksum_reg;

endmodule
